rf_dump_reader: RTL and testbench
=================================

// Module: rf_dump_reader
// PURPOSE
//   Debug reader on a spare RF read port. On a start pulse it walks register
//   addresses FIRST_ADDR..LAST_ADDR, captures each read_data word and presents
//   it downstream (seven-seg/UART formatter) over a valid/ready stream tagged
//   with its address. Lets the board dump CPU register state without halting
//   the datapath.
// PARAMETERS
//   ADDR_WIDTH  5    register address width
//   DATA_WIDTH  32   register data width
//   FIRST_ADDR  0    first address dumped
//   LAST_ADDR   31   last address dumped; must be >= FIRST_ADDR
// PORTS
//   clk           in   1           system clock, rising edge
//   rst_n         in   1           async active-low reset
//   start         in   1           1-cycle request to begin a dump
//   abort         in   1           synchronous cancel of a dump in progress
//   rf_read_addr  out  ADDR_WIDTH  to RF read address port
//   rf_read_data  in   DATA_WIDTH  from RF read data port (combinational)
//   out_data      out  DATA_WIDTH  captured register value
//   out_tag       out  ADDR_WIDTH  address out_data came from
//   out_valid     out  1           out_data/out_tag valid
//   out_ready     in   1           consumer accepts when high with out_valid
//   busy          out  1           high in any state except IDLE
//   done          out  1           1-cycle pulse after last word accepted
// BEHAVIOUR
//   Clock and reset: one clock (clk); rst_n is asynchronous, active-low.
//   Reset (async, rst_n=0): state=IDLE, addr=FIRST_ADDR, out_data=0,
//     out_tag=0, out_valid=0, busy=0, done=0.
//   rf_read_addr = addr register at all times (no combinational path from inputs).
//   FSM IDLE/READ/SEND:
//   - IDLE: start=1 -> addr<=FIRST_ADDR, go READ. Otherwise stay.
//   - READ (1 cycle): at the closing edge out_data<=rf_read_data,
//     out_tag<=addr, out_valid<=1, go SEND.
//   - SEND: out_valid=1; out_data/out_tag held stable until handshake
//     (out_valid & out_ready at a rising edge). On handshake: out_valid<=0;
//     addr==LAST_ADDR -> done<=1 for one cycle, go IDLE;
//     else addr<=addr+1, go READ.
//   - Result: 2 cycles per word with out_ready tied high, so N words take
//     2N cycles from the start edge to the last handshake.
//   - done is asserted the cycle after the last handshake, with busy=0.
//   start while busy: ignored, no restart.
//   abort=1 in READ/SEND: go IDLE at that edge, out_valid<=0, done stays 0,
//     addr<=FIRST_ADDR; a pending word is dropped.
//   abort has priority over handshake in the same cycle.
//   abort in IDLE: no effect.
//   start and abort together in IDLE: start wins.
//   Value captured is RF content during the READ cycle. A same-cycle RF write
//     to that address is not seen (the RF write lands at the same edge).
//   addr never wraps; it is compared to LAST_ADDR before increment.
//   FIRST_ADDR==LAST_ADDR: exactly one word, then done.
//   Reset mid-dump: immediate return to the reset values; no done pulse.
// TESTING
//   1 Preload RF[i]=32'hA5A50000+i, out_ready=1, pulse start -> 32 words, tags
//     0..31, data matches; each out_valid lasts 1 cycle; done 1 cycle after
//     tag 31.
//   2 Same preload, out_ready low 5 cycles on tag 7 -> out_valid held, out_data
//     =32'hA5A50007 stable for 5 cycles; no word skipped or duplicated.
//   3 abort during SEND of tag 12 -> out_valid=0 next cycle, busy=0, no done;
//     a new start restarts at tag 0.
//   4 start re-pulsed at tag 4 -> ignored; sequence continues to tag 31 with
//     a single done.
//   5 rst_n low mid-dump (tag 20), asynchronously between edges -> outputs at
//     reset values immediately; rf_read_addr=FIRST_ADDR.
//   6 FIRST_ADDR=LAST_ADDR=5 -> exactly one word, tag 5, then done;
//     abort and handshake in the same cycle -> no done.

Source files
------------

// File: rtl/rf_dump_reader.sv
// rf_dump_reader: walks register-file addresses FIRST_ADDR..LAST_ADDR on a
// spare read port and streams each captured word, tagged with its address,
// over a valid/ready interface.
//
// Ports:
//   clk, rst_n    clock (rising edge) and asynchronous active-low reset
//   start         1-cycle request to begin a dump (ignored while busy)
//   abort         synchronous cancel of a dump in progress
//   rf_read_addr  read address to the RF (driven straight from a register)
//   rf_read_data  combinational read data from the RF
//   out_data      captured register value
//   out_tag       address out_data came from
//   out_valid     out_data/out_tag valid
//   out_ready     consumer accepts when high together with out_valid
//   busy          high whenever a dump is in progress
//   done          1-cycle pulse after the last word is accepted
module rf_dump_reader #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned FIRST_ADDR = 0,
    parameter int unsigned LAST_ADDR  = 31
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] rf_read_addr,
    input  logic [DATA_WIDTH-1:0] rf_read_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH-1:0] out_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] FirstAddr = ADDR_WIDTH'(FIRST_ADDR);
    localparam logic [ADDR_WIDTH-1:0] LastAddr  = ADDR_WIDTH'(LAST_ADDR);

    typedef enum logic [1:0] {StIdle, StRead, StSend} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [ADDR_WIDTH-1:0] out_tag_q, out_tag_d;
    logic                  out_valid_q, out_valid_d;
    logic                  done_q, done_d;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        out_data_d  = out_data_q;
        out_tag_d   = out_tag_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                // start beats abort here; abort alone does nothing in idle
                if (start) begin
                    addr_d  = FirstAddr;
                    state_d = StRead;
                end
            end
            StRead: begin
                if (abort) begin
                    addr_d      = FirstAddr;
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end else begin
                    out_data_d  = rf_read_data;
                    out_tag_d   = addr_q;
                    out_valid_d = 1'b1;
                    state_d     = StSend;
                end
            end
            StSend: begin
                // abort drops the pending word even if it is being accepted
                if (abort) begin
                    addr_d      = FirstAddr;
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    // compare before incrementing so addr never wraps
                    if (addr_q == LastAddr) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = StRead;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= FirstAddr;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            out_data_q  <= out_data_d;
            out_tag_q   <= out_tag_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign rf_read_addr = addr_q;
    assign out_data     = out_data_q;
    assign out_tag      = out_tag_q;
    assign out_valid    = out_valid_q;
    assign busy         = (state_q != StIdle);
    assign done         = done_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Directed bench for rf_dump_reader: a full-range instance (0..31) and a
// single-word instance (5..5) share one register-file model.
module tb_rf_dump_reader;

    logic        clk;
    logic        rst_n;
    logic        start, abort, out_ready;
    logic [4:0]  rf_read_addr;
    logic [31:0] rf_read_data;
    logic [31:0] out_data;
    logic [4:0]  out_tag;
    logic        out_valid, busy, done;

    logic        start2, abort2, out_ready2;
    logic [4:0]  rf_read_addr2;
    logic [31:0] rf_read_data2;
    logic [31:0] out_data2;
    logic [4:0]  out_tag2;
    logic        out_valid2, busy2, done2;

    logic [31:0] rf [32];

    int checks = 0;
    int passes = 0;

    assign rf_read_data  = rf[rf_read_addr];
    assign rf_read_data2 = rf[rf_read_addr2];

    rf_dump_reader #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .FIRST_ADDR(0), .LAST_ADDR(31)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .rf_read_addr(rf_read_addr), .rf_read_data(rf_read_data),
        .out_data(out_data), .out_tag(out_tag), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .done(done)
    );

    rf_dump_reader #(
        .ADDR_WIDTH(5), .DATA_WIDTH(32), .FIRST_ADDR(5), .LAST_ADDR(5)
    ) dut_one (
        .clk(clk), .rst_n(rst_n), .start(start2), .abort(abort2),
        .rf_read_addr(rf_read_addr2), .rf_read_data(rf_read_data2),
        .out_data(out_data2), .out_tag(out_tag2), .out_valid(out_valid2),
        .out_ready(out_ready2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Sample point while a word should be presented
    task automatic check_word(input int i);
        check("word_valid", {31'b0, out_valid}, 32'd1);
        check("word_tag", {27'b0, out_tag}, 32'(i));
        check("word_data", out_data, 32'hA5A50000 + 32'(i));
        check("word_busy", {31'b0, busy}, 32'd1);
        check("word_no_done", {31'b0, done}, 32'd0);
    endtask

    // One dump from tag 0. stall_tag: hold out_ready low for stall_len cycles
    // on that word. poke_tag: re-pulse start there. cut_tag: abort (cut_rst=0)
    // or async reset (cut_rst=1) while that word is presented. -1 disables.
    task automatic run_dump(input int stall_tag, input int stall_len, input int poke_tag,
                            input int cut_tag, input bit cut_rst);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_busy", {31'b0, busy}, 32'd1);
        check("start_addr", {27'b0, rf_read_addr}, 32'd0);
        check("start_no_valid", {31'b0, out_valid}, 32'd0);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            check_word(i);
            if (i == cut_tag) begin
                if (cut_rst) begin
                    #2 rst_n = 1'b0;
                    #1;
                    check("rst_valid", {31'b0, out_valid}, 32'd0);
                    check("rst_data", out_data, 32'd0);
                    check("rst_tag", {27'b0, out_tag}, 32'd0);
                    check("rst_busy", {31'b0, busy}, 32'd0);
                    check("rst_done", {31'b0, done}, 32'd0);
                    check("rst_addr", {27'b0, rf_read_addr}, 32'd0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    check("post_rst_busy", {31'b0, busy}, 32'd0);
                    check("post_rst_done", {31'b0, done}, 32'd0);
                end else begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    check("abort_valid", {31'b0, out_valid}, 32'd0);
                    check("abort_busy", {31'b0, busy}, 32'd0);
                    check("abort_done", {31'b0, done}, 32'd0);
                    check("abort_addr", {27'b0, rf_read_addr}, 32'd0);
                    @(negedge clk);
                    check("abort_done_later", {31'b0, done}, 32'd0);
                end
                return;
            end
            if (i == poke_tag) start = 1'b1;
            if (i == stall_tag) begin
                repeat (stall_len - 1) begin
                    @(negedge clk);
                    check_word(i);
                end
                out_ready = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            check("gap_valid", {31'b0, out_valid}, 32'd0);
            check("gap_done", {31'b0, done}, (i == 31) ? 32'd1 : 32'd0);
            check("gap_busy", {31'b0, busy}, (i == 31) ? 32'd0 : 32'd1);
            if (i + 1 == stall_tag) out_ready = 1'b0;
        end
        @(negedge clk);
        check("done_one_cycle", {31'b0, done}, 32'd0);
        check("idle_after_done", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf[i] = 32'hA5A50000 + 32'(i);
        rst_n = 1'b0;
        start = 1'b0; abort = 1'b0; out_ready = 1'b1;
        start2 = 1'b0; abort2 = 1'b0; out_ready2 = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_valid", {31'b0, out_valid}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_data", out_data, 32'd0);
        check("reset_addr2", {27'b0, rf_read_addr2}, 32'd5);
        rst_n = 1'b1;
        @(negedge clk);

        // Abort in idle is a no-op
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("idle_abort_busy", {31'b0, busy}, 32'd0);

        run_dump(-1, 0, -1, -1, 1'b0);  // full dump
        run_dump(7, 5, -1, -1, 1'b0);   // backpressure on tag 7
        run_dump(-1, 0, -1, 12, 1'b0);  // abort on tag 12
        run_dump(-1, 0, -1, 0, 1'b0);   // restart from tag 0, then abort
        run_dump(-1, 0, 4, -1, 1'b0);   // re-pulse start at tag 4
        run_dump(-1, 0, -1, 20, 1'b1);  // async reset at tag 20

        // start and abort together in idle: start wins
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_over_abort", {31'b0, busy}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_read", {31'b0, busy}, 32'd0);

        // Single-word instance
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        check("one_busy", {31'b0, busy2}, 32'd1);
        check("one_addr", {27'b0, rf_read_addr2}, 32'd5);
        @(negedge clk);
        check("one_valid", {31'b0, out_valid2}, 32'd1);
        check("one_tag", {27'b0, out_tag2}, 32'd5);
        check("one_data", out_data2, 32'hA5A50005);
        @(negedge clk);
        check("one_done", {31'b0, done2}, 32'd1);
        check("one_idle", {31'b0, busy2}, 32'd0);
        check("one_no_valid", {31'b0, out_valid2}, 32'd0);
        @(negedge clk);
        check("one_done_pulse", {31'b0, done2}, 32'd0);

        // abort and handshake in the same cycle: no done
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        @(negedge clk);
        check("one_valid2", {31'b0, out_valid2}, 32'd1);
        abort2 = 1'b1;
        @(negedge clk);
        abort2 = 1'b0;
        check("abort_hs_done", {31'b0, done2}, 32'd0);
        check("abort_hs_valid", {31'b0, out_valid2}, 32'd0);
        check("abort_hs_busy", {31'b0, busy2}, 32'd0);
        @(negedge clk);
        check("abort_hs_done_later", {31'b0, done2}, 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
